// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide execute unit: 32-step shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed product instead.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            write_enable,
    output logic [4:0]      addr_rd,
    output logic [XLEN-1:0] data_rd
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e              state_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opb_q;
    logic [XLEN-1:0]     data_q;
    logic [4:0]          rd_q;
    logic [4:0]          addr_q;
    logic [4:0]          cnt_q;
    logic [2:0]          f3_q;
    logic                neg_q;
    logic                busy_q;
    logic                done_q;

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    endfunction

    logic            neg_a, neg_b, div_zero, div_ovf, neg_res;
    logic [XLEN-1:0] abs_a, abs_b, fast_res;

    assign neg_a    = a_is_signed(funct3) & op_a[XLEN-1];
    assign neg_b    = b_is_signed(funct3) & op_b[XLEN-1];
    assign abs_a    = neg_a ? -op_a : op_a;
    assign abs_b    = neg_b ? -op_b : op_b;
    // Remainder takes the dividend's sign; quotient and product take the XOR.
    assign neg_res  = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (op_b == '1);
    assign fast_res = div_zero ? (funct3[1] ? op_a : '1)
                               : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration of shift-add multiply or restoring divide on the shared accumulator.
    logic [XLEN:0]     mul_sum, div_shift, div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_d;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_rem   = div_ge ? (div_shift - {1'b0, opb_q}) : div_shift;
    assign acc_d     = f3_q[2] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge}
                               : {mul_sum, acc_q[XLEN-1:1]};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, result_d;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] mul_a, mul_b, prod_s;

    assign mul_a  = {{(XLEN+2){a_is_signed(f3_q) & acc_q[XLEN-1]}}, acc_q[XLEN-1:0]};
    assign mul_b  = {{(XLEN+2){b_is_signed(f3_q) & opb_q[XLEN-1]}}, opb_q};
    assign prod_s = mul_a * mul_b;
    assign prod   = prod_s[2*XLEN-1:0];
`else
    assign prod   = neg_q ? -acc_q : acc_q;
`endif

    assign mul_res  = (f3_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_sel  = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_res  = neg_q ? -div_sel : div_sel;
    assign result_d = f3_q[2] ? div_res : mul_res;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            // NOTE: flush abandons the operation but leaves data_rd/addr_rd holding the last result.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_q  <= funct3;
                        rd_q  <= rd_in;
                        neg_q <= neg_res;
                        cnt_q <= '0;
                        if (div_zero || div_ovf) begin
                            data_q  <= fast_res;
                            addr_q  <= rd_in;
                            state_q <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            acc_q   <= {{XLEN{1'b0}}, op_a};
                            opb_q   <= op_b;
                            busy_q  <= 1'b1;
                            state_q <= FIX;
`endif
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, abs_a};
                            opb_q   <= abs_b;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    data_q  <= result_d;
                    addr_q  <= rd_q;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign write_enable = done_q;
    assign addr_rd      = addr_q;
    assign data_rd      = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of ops plus start-ignore, flush and async-reset sequences.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, write_enable;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .write_enable(write_enable),
        .addr_rd(addr_rd), .data_rd(data_rd)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          fast;
        string       name;
    } vec_t;

    vec_t vecs[22];

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clock);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        funct3 = ~f; op_a = ~a; op_b = ~b; rd_in = ~rd;
    endtask

    // Samples at each falling edge; j=0 is the cycle right after the start edge.
    task automatic wait_done(input int inject_j, input int flush_j, output int lat,
                             output int bcnt, output logic [31:0] data,
                             output logic [4:0] addr, output logic we, output bit seen);
        lat = -1; bcnt = 0; seen = 1'b0; data = '0; addr = '0; we = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clock);
            start = 1'b0;
            flush = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1; lat = j; data = data_rd; addr = addr_rd; we = write_enable;
                break;
            end
            if (j == inject_j) begin
                start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1;
            end
            if (j == flush_j) flush = 1'b1;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, bcnt, exp_lat, exp_busy;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        bit          seen;
        if (v.fast) begin
            exp_lat = 1; exp_busy = 0;
        end else if (!v.f3[2] && FAST_MUL) begin
            exp_lat = 2; exp_busy = 1;
        end else begin
            exp_lat = 34; exp_busy = 33;
        end
        issue(v.f3, v.a, v.b, v.rd);
        wait_done(-1, -1, lat, bcnt, data, addr, we, seen);
        check({v.name, " done_seen"}, 32'(seen), 32'd1);
        check({v.name, " data_rd"}, data, v.exp);
        check({v.name, " addr_rd"}, 32'(addr), 32'(v.rd));
        check({v.name, " write_enable"}, 32'(we), 32'd1);
        check({v.name, " latency"}, lat, exp_lat);
        check({v.name, " busy_cycles"}, bcnt, exp_busy);
        @(negedge clock);
        check({v.name, " done_pulse_len"}, 32'(done), 32'd0);
        check({v.name, " data_hold"}, data_rd, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bcnt;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        bit          seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, "mul_7x-3"};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0, "mulh_min"};
        vecs[2]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h8000_0000, 1'b0, "mulhsu_min"};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h7FFF_FFFF, 1'b0, "mulhu_min"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b0, "div_-7/2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 1'b0, "rem_-7/2"};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd6,  32'd14,        1'b0, "divu_100/7"};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd7,  32'd2,         1'b0, "remu_100/7"};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1'b1, "divu_5/0"};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd9,  32'd5,         1'b1, "rem_5/0"};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, "div_ovf"};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b1, "rem_ovf"};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 1'b0, "mulhu_max"};
        vecs[13] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        1'b0, "mul_rd0"};
        vecs[14] = '{3'd4, 32'd100,       32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, 1'b0, "div_100/-7"};
        vecs[15] = '{3'd6, 32'd100,       32'hFFFF_FFF9, 5'd15, 32'd2,         1'b0, "rem_100/-7"};
        vecs[16] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0, "divu_big"};
        vecs[17] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1'b0, "remu_big"};
        vecs[18] = '{3'd1, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFF, 1'b0, "mulh_neg"};
        vecs[19] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd19, 32'hFFFF_FFFF, 1'b0, "mulhsu_neg"};
        vecs[20] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd20, 32'hFFFF_FFFF, 1'b1, "div_neg/0"};
        vecs[21] = '{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1'b0, "mul_low_min"};

        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset write_enable", 32'(write_enable), 32'd0);
        check("reset addr_rd", 32'(addr_rd), 32'd0);
        check("reset data_rd", data_rd, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) run_vec(vecs[i]);

        // A second start during CALC must not disturb the running divide.
        issue(3'd4, 32'd100, 32'd7, 5'd9);
        wait_done(10, -1, lat, bcnt, data, addr, we, seen);
        check("ignore done_seen", 32'(seen), 32'd1);
        check("ignore data_rd", data, 32'd14);
        check("ignore addr_rd", 32'(addr), 32'd9);
        check("ignore latency", lat, 34);
        check("ignore busy_cycles", bcnt, 33);

        // Flush mid-CALC: no writeback, busy low on the next cycle, outputs keep old values.
        issue(3'd5, 32'd1000, 32'd3, 5'd22);
        wait_done(-1, 20, lat, bcnt, data, addr, we, seen);
        check("flush no_done", 32'(seen), 32'd0);
        check("flush busy_cycles", bcnt, 21);
        check("flush data_hold", data_rd, 32'd14);
        check("flush addr_hold", 32'(addr_rd), 32'd9);
        run_vec('{3'd5, 32'd1000, 32'd3, 5'd22, 32'd333, 1'b0, "after_flush_divu"});

        // Asynchronous reset between edges while CALC is in progress.
        issue(3'd4, 32'd100, 32'd7, 5'd3);
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst done", 32'(done), 32'd0);
        check("async_rst data_rd", data_rd, 32'd0);
        check("async_rst addr_rd", 32'(addr_rd), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        run_vec('{3'd7, 32'd100, 32'd7, 5'd23, 32'd2, 1'b0, "after_rst_remu"});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
